// File: rtl/lock_eval_pkg.sv
// Shared types and default sizing for the locked-multiplier
// corruption monitor.
package lock_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_KEY_W       = 32;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_NUM_VECTORS = 10001;

  function automatic int pop_w(input int width);
    return $clog2(2 * width + 1);
  endfunction

  localparam int POP_W = pop_w(DEF_WIDTH);

endpackage

// File: rtl/hamming_popcount.sv
// Combinational population count of a 2*WIDTH-bit vector.
// Output is wide enough to hold the all-ones count.
module hamming_popcount
  import lock_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0]      i_vec,
  output logic [pop_w(WIDTH)-1:0] o_count
);

  localparam int PW = pop_w(WIDTH);

  always_comb begin
    o_count = '0;
    for (int k = 0; k < 2 * WIDTH; k++) begin
      o_count = o_count + PW'(i_vec[k]);
    end
  end

endmodule

// File: rtl/lock_corruption_monitor.sv
// Counts vectors, mismatching vectors and flipped result bits
// of a locked multiplier over one run of NUM_VECTORS accepts.
module lock_corruption_monitor
  import lock_eval_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NUM_VECTORS = DEF_NUM_VECTORS,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int KEY_W       = DEF_KEY_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   operand1_i,
  input  logic [WIDTH-1:0]   operand2_i,
  input  logic [2*WIDTH-1:0] result_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [KEY_W-1:0]   key_o,
  output logic [CNT_W-1:0]   vec_count_o,
  output logic [CNT_W-1:0]   mismatch_count_o,
  output logic [CNT_W-1:0]   bitflip_count_o
);

  localparam int RW = 2 * WIDTH;
  localparam int PW = pop_w(WIDTH);
  localparam int AW = $clog2(NUM_VECTORS + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e r_state;
  state_e w_next;

  logic [AW-1:0] r_acc;
  logic          w_start;
  logic          w_accept;
  logic          w_last;

  logic             r_s1_v;
  logic [WIDTH-1:0] r_s1_op1;
  logic [WIDTH-1:0] r_s1_op2;
  logic [RW-1:0]    r_s1_res;
  logic             r_s2_v;
  logic [RW-1:0]    r_s2_gold;
  logic [RW-1:0]    r_s2_res;
  logic             r_s3_v;
  logic             r_s3_nz;
  logic [PW-1:0]    r_s3_pop;

  logic [RW-1:0]    w_diff;
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_bf_sum;
  logic [CNT_W-1:0] w_bf_next;

  assign w_start  = start_i && (r_state == IDLE || r_state == DONE);
  assign w_accept = valid_i && (r_state == RUN);
  assign w_last   = w_accept && (r_acc == AW'(NUM_VECTORS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: if (w_start) w_next = RUN;
      RUN:        if (w_last) w_next = DRAIN;
      DRAIN:      if (!(r_s1_v || r_s2_v || r_s3_v)) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      key_o <= '0;
    end else if (w_start) begin
      r_acc <= '0;
      key_o <= key_i;
    end else if (w_accept) begin
      r_acc <= r_acc + AW'(1);
    end
  end

  // Fixed-latency pipeline: capture, golden multiply, compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_op1  <= '0;
      r_s1_op2  <= '0;
      r_s1_res  <= '0;
      r_s2_v    <= 1'b0;
      r_s2_gold <= '0;
      r_s2_res  <= '0;
      r_s3_v    <= 1'b0;
      r_s3_nz   <= 1'b0;
      r_s3_pop  <= '0;
    end else begin
      r_s1_v    <= w_accept;
      r_s1_op1  <= operand1_i;
      r_s1_op2  <= operand2_i;
      r_s1_res  <= result_i;
      r_s2_v    <= r_s1_v;
      r_s2_gold <= RW'(r_s1_op1) * RW'(r_s1_op2);
      r_s2_res  <= r_s1_res;
      r_s3_v    <= r_s2_v;
      r_s3_nz   <= |w_diff;
      r_s3_pop  <= w_pop;
    end
  end

  assign w_diff = r_s2_res ^ r_s2_gold;

  hamming_popcount #(
    .WIDTH(WIDTH)
  ) u_pop (
    .i_vec  (w_diff),
    .o_count(w_pop)
  );

  assign w_bf_sum  = SW'(bitflip_count_o) + SW'(r_s3_pop);
  assign w_bf_next = (w_bf_sum > SW'(CMAX)) ? CMAX
                                            : w_bf_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      vec_count_o      <= '0;
      mismatch_count_o <= '0;
      bitflip_count_o  <= '0;
    end else if (r_s3_v) begin
      if (vec_count_o != CMAX)
        vec_count_o <= vec_count_o + CNT_W'(1);
      if (r_s3_nz && mismatch_count_o != CMAX)
        mismatch_count_o <= mismatch_count_o + CNT_W'(1);
      bitflip_count_o <= w_bf_next;
    end
  end

  assign busy_o = (r_state == RUN) || (r_state == DRAIN);
  assign done_o = (r_state == DONE);

endmodule

// File: doc/lock_corruption_monitor.md
Name: lock_corruption_monitor

Overview:
- Sits directly downstream of the locked 8x8 array multiplier (32-bit key) and consumes its operand pairs and result.
- Each accepted vector is compared against a golden product. Totals accumulated per run: vectors, mismatching vectors, and flipped output bits (Hamming distance).
- One run corresponds to one key setting, e.g. the correct key or a key at Hamming distance 1/2/3/4/6. This gives a synthesizable measure of output corruption per wrong-key distance.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH.
- NUM_VECTORS, 10001, vectors accepted per run.
- CNT_W, 32, width of all counters.
- KEY_W, 32, key width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle pulse; clears counters, latches key_i, begins a run.
- key_i  input  KEY_W  key currently applied to the locked multiplier.
- valid_i  input  1  operand/result triple valid this cycle.
- operand1_i  input  WIDTH  multiplicand.
- operand2_i  input  WIDTH  multiplier.
- result_i  input  2*WIDTH  locked multiplier output for these operands.
- busy_o  output  1  high in RUN or DRAIN.
- done_o  output  1  high in DONE, held until next start_i or rst.
- key_o  output  KEY_W  key latched at start_i.
- vec_count_o  output  CNT_W  vectors accumulated.
- mismatch_count_o  output  CNT_W  vectors with result != golden.
- bitflip_count_o  output  CNT_W  sum of popcount(result ^ golden).

Behaviour:
- Reset (synchronous, active-high, overrides everything including a mid-run state):
  - state IDLE; all outputs 0; pipeline valids cleared.
  - An in-flight run is abandoned with no partial done_o.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start_i--> RUN. Counters zeroed, key_o <= key_i, accept count zeroed.
  - RUN: valid_i accepted; accept count increments. The accept on which count reaches NUM_VECTORS moves the FSM to DRAIN.
  - DRAIN: no accepts. Move to DONE once all 3 pipeline stage valids are 0.
  - start_i is ignored in RUN and DRAIN.
- valid_i is ignored outside RUN and after NUM_VECTORS accepts.
- Pipeline, 3 stages, no backpressure:
  - S1: register operands, result, valid.
  - S2: golden = operand1*operand2, unsigned, full 2*WIDTH; register alongside result.
  - S3: diff = result ^ golden; pop = popcount(diff), width $clog2(2*WIDTH+1); register.
  - Accumulate on S3 valid: vec += 1; mismatch += (diff != 0); bitflip += pop.
- Latency: a triple accepted at edge N is reflected in the counters after edge N+3.
- done_o rises the cycle after the last vector is accumulated, i.e. edge N_last+4.
- Gaps in valid_i are allowed; only valid cycles count.
- Counters saturate at 2^CNT_W-1 and never wrap.
- start_i together with valid_i in IDLE/DONE: the counters clear and the run starts; that cycle's valid_i is not accepted.
- start_i in DONE clears done_o on the same edge that enters RUN.

Decomposition:
- Package lock_eval_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - default WIDTH/KEY_W/CNT_W constants;
  - POP_W localparam function of WIDTH.
- One sub-module, hamming_popcount: combinational popcount of a 2*WIDTH vector, used in S3.
- Golden multiply is inline in S2.

Test Plan:
- NUM_VECTORS=4; start with key_i=32'hF6301537; feed (03,05,000F),(FF,FF,FE01),(00,7A,0000),(12,34,03A8) -> done_o; vec=4, mismatch=0, bitflip=0, key_o=F6301537.
- NUM_VECTORS=2; feed (02,03,0007),(10,10,FF00) -> mismatch=2, bitflip=1+(popcount(0100^FF00)=7)=8.
- valid_i with gaps (1,0,0,1) and extra valid_i after NUM_VECTORS reached -> vec stays NUM_VECTORS; extras ignored; done_o exactly 4 cycles after last accepted edge.
- start_i pulsed mid-RUN -> ignored, counters continue.
- start_i in DONE with new key C6301537 -> counters zero, key_o updates, done_o drops same edge.
- rst asserted mid-RUN for 1 cycle -> all outputs 0, IDLE. A new start runs cleanly with no stale pipeline contribution.
- CNT_W=4; 16 all-bit-flip vectors (result = ~golden) -> bitflip saturates at 15, mismatch saturates at 15, vec saturates at 15.
